timer_irq_ctrl: RTL and testbench

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

---
 rtl/timer_pkg.sv | 24 ++
 rtl/apb_slave_fsm.sv | 49 ++++
 rtl/timer_irq_ctrl.sv | 132 +++++++++++++
 tb/tb_timer_irq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and APB phase encoding for the event timer.
package timer_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_EVCNT  = 2;
  localparam int unsigned ADDR_THRESH = 3;

  localparam int unsigned CTRL_W           = 3;
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
  localparam int unsigned CTRL_ONESHOT_BIT = 2;

  localparam int unsigned STAT_W        = 2;
  localparam int unsigned STAT_PEND_BIT = 0;
  localparam int unsigned STAT_OVF_BIT  = 1;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB phase tracker: qualifies access cycles and flags PENABLE without a preceding SETUP.
module apb_slave_fsm
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic wr_en_c,
  output logic rd_en_c,
  output logic slverr_c
);

  apb_state_e state_q;
  apb_state_e state_d;
  logic       access_ok;
  logic       violation;

  // Only an ACCESS directly following SETUP is legal; anything else is dropped.
  always_comb begin
    state_d   = state_q;
    access_ok = psel & penable & (state_q == APB_SETUP);
    violation = psel & penable & (state_q != APB_SETUP);

    if (!psel) begin
      state_d = APB_IDLE;
    end else if (!penable) begin
      state_d = APB_SETUP;
    end else if (access_ok) begin
      state_d = APB_ACCESS;
    end else begin
      state_d = APB_IDLE;
    end

    wr_en_c  = access_ok & pwrite & ~rst;
    rd_en_c  = access_ok & ~pwrite & ~rst;
    slverr_c = violation & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Edge-counting event timer with threshold interrupt, saturation overflow and APB register access.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [AW-1:0] PADDR,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  input  logic          trig,
  output logic          irq
);

  logic              wr_en_c;
  logic              rd_en_c;
  logic              slverr_c;

  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic              pend_q,   pend_d;
  logic              ovf_q,    ovf_d;
  logic [DW-1:0]     evcnt_q,  evcnt_d;
  logic [DW-1:0]     thresh_q, thresh_d;
  logic              trig_d_q, trig_d_d;

  logic              ev;
  logic              count;
  logic              sat;
  logic              rd_evcnt;
  logic              cnt_upd;
  logic              pend_set;
  logic              ovf_set;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_thresh;
  logic [STAT_W-1:0] w1c;
  logic [DW-1:0]     prdata_c;

  apb_slave_fsm u_apb_fsm (
    .clk      (PCLK),
    .rst      (PRESET),
    .psel     (PSEL),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .wr_en_c  (wr_en_c),
    .rd_en_c  (rd_en_c),
    .slverr_c (slverr_c)
  );

  // Event detection, counter, flags and register writes.
  always_comb begin
    trig_d_d  = trig;
    ev        = trig & ~trig_d_q;
    count     = ev & ctrl_q[CTRL_EN_BIT];
    sat       = &evcnt_q;
    rd_evcnt  = rd_en_c & (PADDR == AW'(ADDR_EVCNT));
    wr_ctrl   = wr_en_c & (PADDR == AW'(ADDR_CTRL));
    wr_status = wr_en_c & (PADDR == AW'(ADDR_STATUS));
    wr_thresh = wr_en_c & (PADDR == AW'(ADDR_THRESH));

    // A clear-on-read restarts the count, keeping a coincident event.
    cnt_upd = count & (rd_evcnt | ~sat);
    evcnt_d = evcnt_q;
    if (rd_evcnt) begin
      evcnt_d = count ? DW'(1) : '0;
    end else if (cnt_upd) begin
      evcnt_d = evcnt_q + DW'(1);
    end

    ovf_set  = count & sat;
    pend_set = cnt_upd & (evcnt_d == thresh_q) & (thresh_q != '0);

    w1c = wr_status ? PWDATA[STAT_W-1:0] : '0;
    pend_d = pend_set | (pend_q & ~w1c[STAT_PEND_BIT]);
    ovf_d  = ovf_set  | (ovf_q  & ~w1c[STAT_OVF_BIT]);

    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = PWDATA[CTRL_W-1:0];
    end
    if (pend_set && ctrl_q[CTRL_ONESHOT_BIT]) begin
      ctrl_d[CTRL_EN_BIT] = 1'b0;
    end

    thresh_d = wr_thresh ? PWDATA : thresh_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      evcnt_q  <= '0;
      thresh_q <= '0;
      trig_d_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      evcnt_q  <= evcnt_d;
      thresh_q <= thresh_d;
      trig_d_q <= trig_d_d;
    end
  end

  // Read mux is only open during a qualified read access.
  always_comb begin
    prdata_c = '0;
    if (rd_en_c) begin
      case (PADDR)
        AW'(ADDR_CTRL):   prdata_c = DW'(ctrl_q);
        AW'(ADDR_STATUS): prdata_c = DW'({ovf_q, pend_q});
        AW'(ADDR_EVCNT):  prdata_c = evcnt_q;
        AW'(ADDR_THRESH): prdata_c = thresh_q;
        default:          prdata_c = '0;
      endcase
    end
  end

  assign PRDATA  = prdata_c;
  assign PREADY  = 1'b1;
  assign PSLVERR = slverr_c;
  assign irq     = pend_q & ctrl_q[CTRL_IRQ_EN_BIT] & ~PRESET;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed and randomized checks of timer_irq_ctrl against a cycle-level behavioural model.
module tb_timer_irq_ctrl;

  logic       PCLK;
  logic       PRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [1:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic       trig;
  logic       irq;

  int n_cmp = 0;
  int n_mis = 0;

  // behavioural model state
  bit m_en, m_irqen, m_oneshot, m_pend, m_ovf, m_trig_prev, m_prev_setup;
  int m_cnt, m_thresh;

  logic [7:0] cap_prdata;
  logic       cap_slverr;
  logic [7:0] rd_val;

  timer_irq_ctrl #(.DW(8), .AW(2)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .trig    (trig),
    .irq     (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_reg(input int a);
    case (a)
      0:       return {29'd0, m_oneshot, m_irqen, m_en};
      1:       return {30'd0, m_ovf, m_pend};
      2:       return m_cnt;
      default: return m_thresh;
    endcase
  endfunction

  // One clock: check combinational outputs against the model, then advance model and DUT.
  task automatic cycle();
    int  exp_rd, new_cnt, a;
    bit  valid, viol, evt, counted, rd_cnt, changed, pend_set, ovf_set, new_en;
    #2;
    cap_prdata = PRDATA;
    cap_slverr = PSLVERR;
    a = int'(PADDR);
    if (PRESET) begin
      check("rst_prdata", {24'd0, PRDATA}, 32'd0);
      check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      {m_en, m_irqen, m_oneshot, m_pend, m_ovf, m_trig_prev, m_prev_setup} = '0;
      m_cnt = 0;
      m_thresh = 0;
    end else begin
      valid  = PSEL && PENABLE && m_prev_setup;
      viol   = PSEL && PENABLE && !m_prev_setup;
      exp_rd = (valid && !PWRITE) ? model_reg(a) : 0;
      check("prdata", {24'd0, PRDATA}, 32'(exp_rd));
      check("pslverr", {31'd0, PSLVERR}, {31'd0, viol});
      check("irq", {31'd0, irq}, {31'd0, m_pend && m_irqen});

      evt     = trig && !m_trig_prev;
      counted = evt && m_en;
      rd_cnt  = valid && !PWRITE && a == 2;
      new_cnt = m_cnt;
      changed = 0;
      ovf_set = 0;
      if (counted) begin
        if (m_cnt == 255) ovf_set = 1;
        else begin new_cnt = m_cnt + 1; changed = 1; end
      end
      if (rd_cnt) begin
        new_cnt = counted ? 1 : 0;
        changed = counted;
      end
      pend_set = changed && new_cnt == m_thresh && m_thresh != 0;

      new_en = m_en;
      if (valid && PWRITE && a == 0) begin
        new_en    = PWDATA[0];
        m_irqen   = PWDATA[1];
      end
      if (pend_set && m_oneshot) new_en = 0;
      if (valid && PWRITE && a == 0) m_oneshot = PWDATA[2];
      m_en = new_en;

      m_pend = pend_set || (m_pend && !(valid && PWRITE && a == 1 && PWDATA[0]));
      m_ovf  = ovf_set  || (m_ovf  && !(valid && PWRITE && a == 1 && PWDATA[1]));
      if (valid && PWRITE && a == 3) m_thresh = int'(PWDATA);
      m_cnt        = new_cnt;
      m_trig_prev  = trig;
      m_prev_setup = PSEL && !PENABLE;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    PSEL = 0; PENABLE = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apb_write(input logic [1:0] addr, input logic [7:0] data);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = addr; PWDATA = data;
    cycle();
    PENABLE = 1;
    cycle();
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic apb_read(input logic [1:0] addr, output logic [7:0] data);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = addr; PWDATA = '0;
    cycle();
    PENABLE = 1;
    cycle();
    data = cap_prdata;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      trig = 1; cycle();
      trig = 0; cycle();
    end
  endtask

  initial begin
    PRESET = 1; PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 2'd3; PWDATA = 8'hFF; trig = 1;
    cycle();
    PENABLE = 0;
    cycle();
    PENABLE = 1;
    cycle();
    PRESET = 0; trig = 0;
    idle(2);
    check("pready", {31'd0, PREADY}, 32'd1);

    apb_read(2'd0, rd_val); check("reset_ctrl",   {24'd0, rd_val}, 32'h00);
    apb_read(2'd1, rd_val); check("reset_status", {24'd0, rd_val}, 32'h00);
    apb_read(2'd2, rd_val); check("reset_evcnt",  {24'd0, rd_val}, 32'h00);
    apb_read(2'd3, rd_val); check("reset_thresh", {24'd0, rd_val}, 32'h00);

    // threshold interrupt and W1C
    apb_write(2'd3, 8'd3);
    apb_write(2'd0, 8'h03);
    pulse(2);
    check("irq_before_thresh", {31'd0, irq}, 32'd0);
    trig = 1; cycle();
    check("irq_after_third", {31'd0, irq}, 32'd1);
    trig = 0; cycle();
    apb_read(2'd1, rd_val); check("status_pend", {24'd0, rd_val}, 32'h01);
    apb_read(2'd2, rd_val); check("evcnt_3",     {24'd0, rd_val}, 32'd3);
    apb_write(2'd1, 8'h01);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    apb_read(2'd1, rd_val); check("status_clear", {24'd0, rd_val}, 32'h00);

    // level held high counts once
    trig = 1; idle(10); trig = 0; idle(1);
    apb_read(2'd2, rd_val); check("held_trig_evcnt", {24'd0, rd_val}, 32'd1);

    // saturation
    apb_write(2'd3, 8'd0);
    pulse(256);
    apb_read(2'd1, rd_val); check("sat_status", {24'd0, rd_val}, 32'h02);
    apb_read(2'd2, rd_val); check("sat_evcnt",  {24'd0, rd_val}, 32'd255);
    apb_write(2'd1, 8'h02);
    apb_read(2'd1, rd_val); check("ovf_clear", {24'd0, rd_val}, 32'h00);

    // read coinciding with an event
    pulse(2);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 2'd2; trig = 0;
    cycle();
    PENABLE = 1; trig = 1;
    cycle();
    check("rd_evt_old", {24'd0, cap_prdata}, 32'd2);
    PSEL = 0; PENABLE = 0; trig = 0;
    cycle();
    apb_read(2'd2, rd_val); check("rd_evt_after", {24'd0, rd_val}, 32'd1);

    // access without setup is rejected
    apb_write(2'd3, 8'h5A);
    idle(1);
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 2'd3; PWDATA = 8'hFF;
    cycle();
    check("noset_pslverr", {31'd0, cap_slverr}, 32'd1);
    idle(1);
    apb_read(2'd3, rd_val); check("noset_thresh", {24'd0, rd_val}, 32'h5A);

    // one-shot
    apb_read(2'd2, rd_val);
    apb_write(2'd3, 8'd2);
    apb_write(2'd0, 8'h07);
    pulse(2);
    apb_read(2'd1, rd_val); check("oneshot_pend", {24'd0, rd_val}, 32'h01);
    apb_read(2'd0, rd_val); check("oneshot_ctrl", {24'd0, rd_val}, 32'h06);
    pulse(1);
    apb_read(2'd2, rd_val); check("oneshot_evcnt", {24'd0, rd_val}, 32'd2);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      PRESET  = ($urandom_range(0, 199) == 0);
      PSEL    = ($urandom_range(0, 3) != 0);
      PENABLE = $urandom_range(0, 1) == 1;
      PWRITE  = $urandom_range(0, 1) == 1;
      PADDR   = 2'($urandom_range(0, 3));
      PWDATA  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      trig    = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
